tx_burst_scheduler: RTL
=======================

TX_BURST_SCHEDULER -- requirements
Module: tx_burst_scheduler

Interface
REQ-001 SHALL have parameter LEN_W, default 16: width of burst-length and remaining-count fields.
REQ-002 SHALL have parameter ARM_TIMEOUT, default 1023: cycles allowed in ARM before timeout (used only with TX_SCHED_TIMEOUT_EN).
REQ-003 SHALL have port i_sys_clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port i_start  input  1  one-cycle burst start request.
REQ-006 SHALL have port i_abort  input  1  one-cycle burst abort request.
REQ-007 SHALL have port i_burst_len  input  LEN_W  samples in burst, sampled on accepted start.
REQ-008 SHALL have port i_gap  input  4  inter-sample gap in frames, sampled on accepted start.
REQ-009 SHALL have port i_lb_req  input  1  level, loopback-pattern request.
REQ-010 SHALL have port i_tx_active  input  1  TX serializer in transmit state, already synchronized to i_sys_clk.
REQ-011 SHALL have port i_sample_done  input  1  one-cycle pulse per sample consumed by serializer, already synchronized.
REQ-012 SHALL have port o_tx_state  output  1  transmit enable to serializer.
REQ-013 SHALL have port o_sample_gap  output  4  gap setting to serializer.
REQ-014 SHALL have port o_debug_lb  output  1  loopback enable to serializer.
REQ-015 SHALL have port o_busy  output  1  high in any state other than IDLE.
REQ-016 SHALL have port o_done  output  1  one-cycle pulse on burst completion or abort completion.
REQ-017 SHALL have port o_aborted  output  1  status of last burst; 1 = ended by abort or timeout.
REQ-018 SHALL have port o_remaining  output  LEN_W  samples still to transmit.

Function
REQ-019 SHALL implement states IDLE, ARM, RUN, DRAIN, LOOP; all outputs registered.
REQ-020 IDLE: o_tx_state=0, o_debug_lb=0, o_sample_gap=0; i_abort ignored.
REQ-021 IDLE with i_lb_req=1 SHALL go to LOOP next cycle; i_lb_req has priority over i_start.
REQ-022 IDLE with i_start=1, i_lb_req=0, i_burst_len!=0 SHALL latch len/gap, clear o_aborted, go to ARM with o_tx_state=1 and o_sample_gap=gap one cycle later.
REQ-023 IDLE with i_start=1, i_burst_len=0 SHALL pulse o_done next cycle, clear o_aborted, remain IDLE.
REQ-024 ARM: on i_tx_active=1 SHALL go to RUN.
REQ-025 RUN: each i_sample_done SHALL decrement o_remaining by 1; when decrement reaches 0 SHALL go to DRAIN and drop o_tx_state in the same update.
REQ-026 ARM/RUN with i_abort=1 SHALL go to DRAIN, drop o_tx_state, set o_aborted=1; abort wins over a simultaneous final i_sample_done (o_remaining still decremented).
REQ-027 i_sample_done outside RUN SHALL be ignored; o_remaining never wraps below 0.
REQ-028 DRAIN: on i_tx_active=0 SHALL go to IDLE, pulse o_done, zero o_sample_gap.
REQ-029 i_start outside IDLE SHALL be ignored.
REQ-030 LOOP: o_debug_lb=1, o_tx_state=0; on i_lb_req=0 SHALL return to IDLE with o_debug_lb=0 next cycle.

Reset
REQ-031 Assertion of i_rst SHALL immediately force IDLE, all outputs 0, o_remaining=0, regardless of state (mid-burst included).
REQ-032 No o_done pulse SHALL be generated by reset.

Configuration
REQ-033 With TX_SCHED_TIMEOUT_EN defined: ARM cycles counted; after ARM_TIMEOUT cycles without i_tx_active SHALL go to DRAIN with o_aborted=1.
REQ-034 Without TX_SCHED_TIMEOUT_EN: no counter; ARM waits indefinitely.

Verification
REQ-035 len=3, gap=2, start; raise i_tx_active; 3 sample_done pulses; drop i_tx_active -> o_remaining 3,2,1,0; o_tx_state falls with 3rd pulse; one o_done, o_aborted=0.
REQ-036 len=100, start, 10 sample_done, abort -> DRAIN, o_remaining=90, o_aborted=1, o_done after i_tx_active=0.
REQ-037 len=0 start -> o_done next cycle, o_busy stays 0, o_tx_state stays 0.
REQ-038 i_lb_req=1 and i_start=1 same cycle in IDLE -> LOOP, o_debug_lb=1, o_tx_state=0; release -> IDLE.
REQ-039 Assert i_rst in RUN with o_remaining=5 -> all outputs 0 without waiting for a clock edge, no o_done.
REQ-040 With TX_SCHED_TIMEOUT_EN, ARM_TIMEOUT=8, start, i_tx_active held 0 -> DRAIN after 8 cycles, o_aborted=1, o_done.

Source files
------------

// File: rtl/tx_burst_scheduler.sv
// Burst scheduler driving a TX serializer: arms, counts samples, drains, and hosts a loopback mode.
// Optional ARM watchdog enabled with `define TX_SCHED_TIMEOUT_EN.
module tx_burst_scheduler #(
    parameter int LEN_W       = 16,
    parameter int ARM_TIMEOUT = 1023
) (
    input  logic             i_sys_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [LEN_W-1:0] i_burst_len,
    input  logic [3:0]       i_gap,
    input  logic             i_lb_req,
    input  logic             i_tx_active,
    input  logic             i_sample_done,
    output logic             o_tx_state,
    output logic [3:0]       o_sample_gap,
    output logic             o_debug_lb,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_aborted,
    output logic [LEN_W-1:0] o_remaining
);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        RUN,
        DRAIN,
        LOOP
    } state_t;

    state_t state;
    logic   arm_expired;

`ifdef TX_SCHED_TIMEOUT_EN
    localparam int CNT_W = (ARM_TIMEOUT > 1) ? $clog2(ARM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] ARM_LAST = CNT_W'(ARM_TIMEOUT - 1);

    logic [CNT_W-1:0] arm_cnt;

    // Counts consecutive ARM cycles spent waiting for the serializer; restarts on every ARM entry.
    always_ff @(posedge i_sys_clk or posedge i_rst) begin
        if (i_rst) begin
            arm_cnt <= '0;
        end else if (state != ARM) begin
            arm_cnt <= '0;
        end else if (!i_tx_active) begin
            arm_cnt <= arm_cnt + CNT_W'(1);
        end
    end

    assign arm_expired = (arm_cnt == ARM_LAST) && !i_tx_active;
`else
    logic unused_timeout;
    assign unused_timeout = (ARM_TIMEOUT == 0);
    assign arm_expired    = 1'b0;
`endif

    always_ff @(posedge i_sys_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= IDLE;
            o_tx_state   <= 1'b0;
            o_sample_gap <= 4'd0;
            o_debug_lb   <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_aborted    <= 1'b0;
            o_remaining  <= '0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_lb_req) begin
                        state      <= LOOP;
                        o_debug_lb <= 1'b1;
                        o_busy     <= 1'b1;
                    end else if (i_start) begin
                        o_aborted   <= 1'b0;
                        o_remaining <= i_burst_len;
                        if (i_burst_len != '0) begin
                            state        <= ARM;
                            o_sample_gap <= i_gap;
                            o_tx_state   <= 1'b1;
                            o_busy       <= 1'b1;
                        end else begin
                            o_done <= 1'b1;
                        end
                    end
                end
                ARM: begin
                    if (i_abort || arm_expired) begin
                        state      <= DRAIN;
                        o_tx_state <= 1'b0;
                        o_aborted  <= 1'b1;
                    end else if (i_tx_active) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    // Abort still lets a coincident sample count, but owns the DRAIN status.
                    if (i_sample_done && (o_remaining != '0)) begin
                        o_remaining <= o_remaining - LEN_W'(1);
                    end
                    if (i_abort) begin
                        state      <= DRAIN;
                        o_tx_state <= 1'b0;
                        o_aborted  <= 1'b1;
                    end else if (i_sample_done && (o_remaining == LEN_W'(1))) begin
                        state      <= DRAIN;
                        o_tx_state <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (!i_tx_active) begin
                        state        <= IDLE;
                        o_done       <= 1'b1;
                        o_sample_gap <= 4'd0;
                        o_busy       <= 1'b0;
                    end
                end
                LOOP: begin
                    if (!i_lb_req) begin
                        state      <= IDLE;
                        o_debug_lb <= 1'b0;
                        o_busy     <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
